// File: rtl/cmac_rx_gate.sv
// -----------------------------------------------------------------------------
// cmac_rx_gate
//
// Gates the CMAC receive AXI-Stream on PCS alignment. The stream is only
// passed downstream once the link is aligned and the input has reached a
// packet boundary, so the output never starts mid-packet. If alignment is
// lost while an output packet is open, a single truncation beat (tlast=1,
// tuser=1) closes it so the consumer sees a terminated, errored packet.
//
// States: DOWN (not aligned, discard), SYNC (aligned, discard until a packet
// boundary), PASS (forward with one cycle of latency).
//
// Configuration macro: CMAC_RX_GATE_STATS_EN
//   defined   -> pkt/drop/err/trunc counters implemented (saturating at 2^32-1)
//   undefined -> counter outputs tied to 0, no counter registers
//
// Ports:
//   rx_clk, rx_resetn      clock and asynchronous active-low reset
//   link_aligned           PCS alignment, synchronous to rx_clk
//   axis_in_*              CMAC rx stream (no tready, never backpressured)
//   axis_out_*             gated stream, all fields registered (no tready)
//   link_up                high while in PASS
//   pkt_count              forwarded good packets (tlast with tuser=0)
//   drop_count             discarded tlast beats
//   err_count              forwarded errored packets (tlast with tuser=1)
//   trunc_count            truncation beats emitted
// -----------------------------------------------------------------------------
module cmac_rx_gate #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  rx_clk,
   input  logic                  rx_resetn,
   input  logic                  link_aligned,
   input  logic [DATA_WIDTH-1:0] axis_in_tdata,
   input  logic [KEEP_WIDTH-1:0] axis_in_tkeep,
   input  logic                  axis_in_tlast,
   input  logic                  axis_in_tuser,
   input  logic                  axis_in_tvalid,
   output logic [DATA_WIDTH-1:0] axis_out_tdata,
   output logic [KEEP_WIDTH-1:0] axis_out_tkeep,
   output logic                  axis_out_tlast,
   output logic                  axis_out_tuser,
   output logic                  axis_out_tvalid,
   output logic                  link_up,
   output logic [31:0]           pkt_count,
   output logic [31:0]           drop_count,
   output logic [31:0]           err_count,
   output logic [31:0]           trunc_count
);

   typedef enum logic [1:0] {
      ST_DOWN = 2'd0,
      ST_SYNC = 2'd1,
      ST_PASS = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   in_pkt_q, in_pkt_d;
   logic   out_pkt_q, out_pkt_d;

   logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
   logic [KEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
   logic                  out_tlast_q, out_tlast_d;
   logic                  out_tuser_q, out_tuser_d;
   logic                  out_tvalid_q, out_tvalid_d;

   // Forwarding happens only in PASS while still aligned; the beat that
   // arrives in the cycle alignment drops is discarded.
   logic pass_fwd;
   logic trunc_now;

   assign pass_fwd  = (state_q == ST_PASS) && link_aligned;
   // out_pkt_q already includes the beat currently held in the output
   // register, so it says whether the downstream packet is still open.
   assign trunc_now = (state_q == ST_PASS) && !link_aligned && out_pkt_q;

   always_comb begin
      state_d      = state_q;
      in_pkt_d     = in_pkt_q;
      out_pkt_d    = out_pkt_q;
      out_tdata_d  = '0;
      out_tkeep_d  = '0;
      out_tlast_d  = 1'b0;
      out_tuser_d  = 1'b0;
      out_tvalid_d = 1'b0;

      if (axis_in_tvalid) begin
         in_pkt_d = ~axis_in_tlast;
      end

      case (state_q)
         ST_DOWN: begin
            if (link_aligned) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (!link_aligned) begin
               state_d = ST_DOWN;
            end else if (axis_in_tvalid && axis_in_tlast) begin
               // Boundary reached by discarding the tail of a packet.
               state_d = ST_PASS;
            end else if (!in_pkt_q && !axis_in_tvalid) begin
               // Idle between packets: safe to start forwarding.
               state_d = ST_PASS;
            end
         end
         ST_PASS: begin
            if (!link_aligned) begin
               state_d = ST_DOWN;
            end
         end
         default: begin
            state_d = ST_DOWN;
         end
      endcase

      if (pass_fwd) begin
         out_tdata_d  = axis_in_tdata;
         out_tkeep_d  = axis_in_tkeep;
         out_tlast_d  = axis_in_tlast;
         out_tuser_d  = axis_in_tuser;
         out_tvalid_d = axis_in_tvalid;
      end else if (trunc_now) begin
         out_tkeep_d  = KEEP_WIDTH'(1);
         out_tlast_d  = 1'b1;
         out_tuser_d  = 1'b1;
         out_tvalid_d = 1'b1;
      end

      if (out_tvalid_d) begin
         out_pkt_d = ~out_tlast_d;
      end
   end

   always_ff @(posedge rx_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         state_q      <= ST_DOWN;
         in_pkt_q     <= 1'b0;
         out_pkt_q    <= 1'b0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tuser_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_pkt_q     <= in_pkt_d;
         out_pkt_q    <= out_pkt_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tlast_q  <= out_tlast_d;
         out_tuser_q  <= out_tuser_d;
         out_tvalid_q <= out_tvalid_d;
      end
   end

   assign axis_out_tdata  = out_tdata_q;
   assign axis_out_tkeep  = out_tkeep_q;
   assign axis_out_tlast  = out_tlast_q;
   assign axis_out_tuser  = out_tuser_q;
   assign axis_out_tvalid = out_tvalid_q;
   assign link_up         = (state_q == ST_PASS);

`ifdef CMAC_RX_GATE_STATS_EN
   // Counter events are taken at the edge where the beat is loaded into the
   // output register, so counts line up with the beat appearing downstream.
   logic ev_pkt, ev_err, ev_drop, ev_trunc;

   assign ev_pkt   = pass_fwd && axis_in_tvalid && axis_in_tlast && !axis_in_tuser;
   assign ev_err   = pass_fwd && axis_in_tvalid && axis_in_tlast &&  axis_in_tuser;
   assign ev_drop  = !pass_fwd && axis_in_tvalid && axis_in_tlast;
   assign ev_trunc = trunc_now;

   logic [31:0] pkt_cnt_q, drop_cnt_q, err_cnt_q, trunc_cnt_q;

   always_ff @(posedge rx_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         err_cnt_q   <= '0;
         trunc_cnt_q <= '0;
      end else begin
         if (ev_pkt && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (ev_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
         end
         if (ev_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_q <= err_cnt_q + 32'd1;
         end
         if (ev_trunc && (trunc_cnt_q != 32'hFFFF_FFFF)) begin
            trunc_cnt_q <= trunc_cnt_q + 32'd1;
         end
      end
   end

   assign pkt_count   = pkt_cnt_q;
   assign drop_count  = drop_cnt_q;
   assign err_count   = err_cnt_q;
   assign trunc_count = trunc_cnt_q;
`else
   assign pkt_count   = 32'd0;
   assign drop_count  = 32'd0;
   assign err_count   = 32'd0;
   assign trunc_count = 32'd0;
`endif

endmodule
